// File: rtl/ascon_pkg.sv
// Shared types and constants for the ASCON inverse substitution layer.
// Holds the state packing, the control FSM encoding and the inverse S-box table.
package ascon_pkg;

    localparam int STATE_W = 320;
    localparam int COLS    = 64;
    localparam int LANE_W  = 64;

    typedef logic [STATE_W-1:0] state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    // Index is the column value {x0,x1,x2,x3,x4}; x0 is the MSB.
    localparam logic [4:0] INV_SBOX [32] = '{
        5'h14, 5'h1A, 5'h07, 5'h0D, 5'h00, 5'h09, 5'h0E, 5'h12,
        5'h0A, 5'h06, 5'h1D, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1E,
        5'h18, 5'h16, 5'h0B, 5'h11, 5'h03, 5'h05, 5'h1C, 5'h1F,
        5'h17, 5'h1B, 5'h04, 5'h08, 5'h0F, 5'h0C, 5'h10, 5'h02
    };

endpackage

// File: rtl/sbox_inv.sv
// Combinational 5-bit inverse ASCON S-box lookup.
// One instance handles one column per clock.
module sbox_inv
    import ascon_pkg::*;
(
    input  logic [4:0] x_i,
    output logic [4:0] y_o
);

    assign y_o = INV_SBOX[x_i];

endmodule

// File: rtl/ascon_inv_sub_layer.sv
// Iterative inverse ASCON substitution layer over the 320-bit state.
// Handshake: a word moves on a side only in a cycle where its valid and ready are both 1.
module ascon_inv_sub_layer
    import ascon_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 8
)
(
    input  logic   clock_i,
    input  logic   resetb_i,
    input  state_t state_i,
    input  logic   valid_i,
    output logic   ready_o,
    output state_t state_o,
    output logic   valid_o,
    input  logic   ready_i,
    output logic   busy_o,
    output fsm_t   state_dbg_o
);

    localparam int GROUPS = COLS / COLS_PER_CYCLE;
    localparam int CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [CNT_W-1:0] LAST_GRP = CNT_W'(GROUPS - 1);

    fsm_t             state_q;
    logic [CNT_W-1:0] col_cnt_q;
    state_t           work_q;
    state_t           work_d;

    logic [5:0] base;
    logic [8:0] col    [COLS_PER_CYCLE];
    logic [4:0] sb_in  [COLS_PER_CYCLE];
    logic [4:0] sb_out [COLS_PER_CYCLE];

    always_comb begin
        base = 6'(int'(col_cnt_q) * COLS_PER_CYCLE);
    end

    // Gather column bits: bit r of the S-box word lives in lane (4-r), at offset 64*r.
    always_comb begin
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            col[k]   = {3'b000, base + 6'(k)};
            sb_in[k] = '0;
            for (int r = 0; r < 5; r++) begin
                sb_in[k][r] = work_q[col[k] + 9'(LANE_W * r)];
            end
        end
    end

    generate
        for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_sbox
            sbox_inv u_sbox (
                .x_i (sb_in[g]),
                .y_o (sb_out[g])
            );
        end
    endgenerate

    always_comb begin
        work_d = work_q;
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            for (int r = 0; r < 5; r++) begin
                work_d[col[k] + 9'(LANE_W * r)] = sb_out[k][r];
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (!resetb_i) begin
            state_q   <= IDLE;
            col_cnt_q <= '0;
            work_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        work_q    <= state_i;
                        col_cnt_q <= '0;
                        state_q   <= RUN;
                    end
                end
                RUN: begin
                    work_q <= work_d;
                    if (col_cnt_q == LAST_GRP) begin
                        state_q <= DONE;
                    end else begin
                        col_cnt_q <= col_cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready_o     = (state_q == IDLE);
    assign valid_o     = (state_q == DONE);
    assign busy_o      = (state_q != IDLE);
    assign state_o     = work_q;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_ascon_inv_sub_layer.sv
// Directed bench for ascon_inv_sub_layer at 1, 8 and 64 columns per cycle.
// Hand-computed vectors plus forward-S-box round trips, backpressure and mid-run reset.
module tb_ascon_inv_sub_layer;
    import ascon_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic   resetb;
    state_t st_in;
    logic   valid_in;
    logic   ready_in;

    logic   rdy1, rdy8, rdy64, vld1, vld8, vld64, bsy1, bsy8, bsy64;
    state_t so1, so8, so64;
    fsm_t   dbg1, dbg8, dbg64;

    ascon_inv_sub_layer #(.COLS_PER_CYCLE(1)) u_c1 (
        .clock_i(clk), .resetb_i(resetb), .state_i(st_in), .valid_i(valid_in),
        .ready_o(rdy1), .state_o(so1), .valid_o(vld1), .ready_i(ready_in),
        .busy_o(bsy1), .state_dbg_o(dbg1)
    );
    ascon_inv_sub_layer u_c8 (
        .clock_i(clk), .resetb_i(resetb), .state_i(st_in), .valid_i(valid_in),
        .ready_o(rdy8), .state_o(so8), .valid_o(vld8), .ready_i(ready_in),
        .busy_o(bsy8), .state_dbg_o(dbg8)
    );
    ascon_inv_sub_layer #(.COLS_PER_CYCLE(64)) u_c64 (
        .clock_i(clk), .resetb_i(resetb), .state_i(st_in), .valid_i(valid_in),
        .ready_o(rdy64), .state_o(so64), .valid_o(vld64), .ready_i(ready_in),
        .busy_o(bsy64), .state_dbg_o(dbg64)
    );

    localparam logic [63:0] O = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] Z = 64'h0;
    localparam logic [4:0] FWD [32] = '{
        5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
        5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
        5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
        5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17
    };

    int n_tests = 0;
    int n_fail  = 0;
    int lat1, lat8, lat64;

    task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic state_t fwd(input state_t s);
        state_t     r;
        logic [4:0] v;
        r = s;
        for (int j = 0; j < 64; j++) begin
            v = FWD[{s[256+j], s[192+j], s[128+j], s[64+j], s[j]}];
            r[256+j] = v[4];
            r[192+j] = v[3];
            r[128+j] = v[2];
            r[64+j]  = v[1];
            r[j]     = v[0];
        end
        return r;
    endfunction

    // Launch one state with ready_in low so every instance parks in DONE.
    task automatic launch(input string tag, input state_t s);
        chk({tag, "_ready_in"}, 320'({rdy1, rdy8, rdy64}), 320'(3'b111));
        ready_in = 1'b0;
        @(negedge clk);
        st_in    = s;
        valid_in = 1'b1;
        @(posedge clk);
        #1 valid_in = 1'b0;
        lat1 = 0; lat8 = 0; lat64 = 0;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            @(posedge clk);
            #1;
            if (vld1 && lat1 == 0) lat1 = cyc;
            if (vld8 && lat8 == 0) lat8 = cyc;
            if (vld64 && lat64 == 0) lat64 = cyc;
            if (lat1 != 0 && lat8 != 0 && lat64 != 0) break;
        end
        chk({tag, "_lat1"}, 320'(lat1), 320'(64));
        chk({tag, "_lat8"}, 320'(lat8), 320'(8));
        chk({tag, "_lat64"}, 320'(lat64), 320'(1));
    endtask

    task automatic release_out(input string tag);
        @(negedge clk);
        ready_in = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, "_idle_after"}, 320'({rdy1, rdy8, rdy64, vld1, vld8, vld64}), 320'(6'b111000));
    endtask

    task automatic run_vec(input string tag, input state_t s, input state_t exp);
        launch(tag, s);
        chk({tag, "_out1"}, so1, exp);
        chk({tag, "_out8"}, so8, exp);
        chk({tag, "_out64"}, so64, exp);
        release_out(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        state_t orig;
        state_t e0;

        e0       = {O, Z, O, Z, Z};
        resetb   = 1'b0;
        valid_in = 1'b0;
        ready_in = 1'b1;
        st_in    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_flags", 320'({vld8, rdy8, bsy8}), 320'(3'b010));
        chk("reset_state_o", so8, '0);
        chk("reset_dbg", 320'(dbg8), 320'(IDLE));
        chk("reset_other", 320'({rdy1, rdy64, bsy1, bsy64}), 320'(4'b1100));
        @(negedge clk);
        resetb = 1'b1;

        run_vec("zero", '0, e0);
        run_vec("ones", {5{O}}, {Z, Z, Z, O, Z});
        run_vec("x4_ones", {Z, Z, Z, Z, O}, {O, O, Z, O, Z});
        run_vec("x0_upper", {64'hFFFF_FFFF_0000_0000, Z, Z, Z, Z},
                {O, 64'hFFFF_FFFF_0000_0000, 64'h0000_0000_FFFF_FFFF, Z, Z});

        for (int n = 0; n < 20; n++) begin
            for (int w = 0; w < 10; w++) orig[w*32 +: 32] = $urandom;
            run_vec($sformatf("rt%0d", n), fwd(orig), orig);
        end

        // Backpressure: hold DONE for 20 cycles with a stray valid in the middle.
        launch("bp", '0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            st_in    = {5{O}};
            valid_in = (i == 5);
            @(posedge clk);
            #1;
            chk($sformatf("bp_flags%0d", i), 320'({vld8, rdy8, bsy8}), 320'(3'b101));
            chk($sformatf("bp_state%0d", i), so8, e0);
        end
        valid_in = 1'b0;
        release_out("bp");
        repeat (3) @(posedge clk);
        #1;
        chk("bp_no_reaccept", 320'({bsy1, bsy8, bsy64}), 320'(3'b000));
        chk("bp_state_kept", so8, e0);

        // Reset during the third RUN cycle.
        @(negedge clk);
        st_in    = '0;
        valid_in = 1'b1;
        @(posedge clk);
        #1 valid_in = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetb = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_flags", 320'({vld8, rdy8, bsy8}), 320'(3'b010));
        chk("rst_mid_state", so8, '0);
        chk("rst_mid_c1", 320'({vld1, rdy1, bsy1}), 320'(3'b010));
        chk("rst_mid_c1_state", so1, '0);
        @(negedge clk);
        resetb = 1'b1;
        run_vec("after_rst", '0, e0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
